// File: rtl/ps2_message_controller_if.sv
// rtl/ps2_message_controller_if.sv - key/send/gpio handshake bundle for ps2_message_controller
interface ps2_message_controller_if #(
    parameter int MSG_CHARS = 16,
    parameter int CNT_W     = 5
);
    logic                   key_valid;
    logic [7:0]             key_ascii;
    logic                   send_req;
    logic                   tx_done;
    logic [MSG_CHARS*8-1:0] message;
    logic [CNT_W-1:0]       char_count;
    logic                   data_ready;
    logic                   busy;
    logic                   overflow;
    logic                   dropped_busy;

    modport master (
        output key_valid, key_ascii, send_req, tx_done,
        input  message, char_count, data_ready, busy, overflow, dropped_busy
    );

    modport slave (
        input  key_valid, key_ascii, send_req, tx_done,
        output message, char_count, data_ready, busy, overflow, dropped_busy
    );
endinterface

// File: rtl/ps2_message_controller.sv
// rtl/ps2_message_controller.sv - PS/2 key buffer with backspace edit and gpio send handshake; PS2_MSG_AUTO_SEND_EN enables send on full
module ps2_message_controller #(
    parameter int MSG_CHARS     = 16,
    parameter int CNT_W         = 5,
    parameter int CLEAR_ON_DONE = 1
) (
    input  logic                    clock,
    input  logic                    RESETN,
    ps2_message_controller_if.slave bus
);
    typedef enum logic [1:0] {
        ST_EDIT         = 2'd0,
        ST_SEND         = 2'd1,
        ST_WAIT_RELEASE = 2'd2,
        ST_CLEAR        = 2'd3
    } state_t;

    localparam int                   MSG_W  = MSG_CHARS * 8;
    localparam logic [CNT_W-1:0]     FULL   = CNT_W'(MSG_CHARS);
    localparam logic [7:0]           DEL    = 8'd127;
    localparam logic [MSG_W-1:0]     SPACES = {MSG_CHARS{8'h20}};

    state_t           state_q, state_d;
    logic [MSG_W-1:0] msg_q, msg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             data_ready_q, data_ready_d;
    logic             busy_q, busy_d;
    logic             overflow_q, overflow_d;
    logic             dropped_q, dropped_d;
    logic             sreq_q, sreq_d;
    logic             sreq_prev_q, sreq_prev_d;
    logic             send_rise;
`ifdef PS2_MSG_AUTO_SEND_EN
    logic             auto_q, auto_d;
`endif

    assign send_rise = sreq_q & ~sreq_prev_q;

    always_comb begin
        state_d      = state_q;
        msg_d        = msg_q;
        cnt_d        = cnt_q;
        data_ready_d = data_ready_q;
        overflow_d   = overflow_q;
        dropped_d    = dropped_q;
        sreq_d       = bus.send_req;
        sreq_prev_d  = sreq_q;
`ifdef PS2_MSG_AUTO_SEND_EN
        auto_d       = 1'b0;
`endif
        case (state_q)
            ST_EDIT: begin
                if (bus.key_valid) begin
                    if (bus.key_ascii != DEL) begin
                        if (cnt_q < FULL) begin
                            for (int i = 0; i < MSG_CHARS; i++) begin
                                if (CNT_W'(i) == cnt_q)
                                    msg_d[(MSG_CHARS-1-i)*8 +: 8] = bus.key_ascii;
                            end
                            cnt_d = cnt_q + 1'b1;
`ifdef PS2_MSG_AUTO_SEND_EN
                            auto_d = (cnt_q + 1'b1 == FULL);
`endif
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end else if (cnt_q != '0) begin
                        for (int i = 0; i < MSG_CHARS; i++) begin
                            if (CNT_W'(i) == cnt_q - 1'b1)
                                msg_d[(MSG_CHARS-1-i)*8 +: 8] = 8'h20;
                        end
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                // The edge was registered a cycle earlier, so a key coincident with
                // the raw send_req rise has already landed in the buffer.
`ifdef PS2_MSG_AUTO_SEND_EN
                if (send_rise || auto_q) begin
`else
                if (send_rise) begin
`endif
                    state_d      = ST_SEND;
                    data_ready_d = 1'b1;
                end
            end
            ST_SEND: begin
                if (bus.key_valid) dropped_d = 1'b1;
                if (bus.tx_done) begin
                    data_ready_d = 1'b0;
                    state_d      = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (bus.key_valid) dropped_d = 1'b1;
                if (!bus.tx_done)
                    state_d = (CLEAR_ON_DONE != 0) ? ST_CLEAR : ST_EDIT;
            end
            default: begin
                if (bus.key_valid) dropped_d = 1'b1;
                msg_d      = SPACES;
                cnt_d      = '0;
                overflow_d = 1'b0;
                state_d    = ST_EDIT;
            end
        endcase
        busy_d = (state_d != ST_EDIT);
    end

    // Edge detector resets high so a send_req held through reset is not a request.
    always_ff @(posedge clock or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= ST_EDIT;
            msg_q        <= SPACES;
            cnt_q        <= '0;
            data_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            dropped_q    <= 1'b0;
            sreq_q       <= 1'b1;
            sreq_prev_q  <= 1'b1;
`ifdef PS2_MSG_AUTO_SEND_EN
            auto_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            msg_q        <= msg_d;
            cnt_q        <= cnt_d;
            data_ready_q <= data_ready_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
            dropped_q    <= dropped_d;
            sreq_q       <= sreq_d;
            sreq_prev_q  <= sreq_prev_d;
`ifdef PS2_MSG_AUTO_SEND_EN
            auto_q       <= auto_d;
`endif
        end
    end

    assign bus.message      = msg_q;
    assign bus.char_count   = cnt_q;
    assign bus.data_ready   = data_ready_q;
    assign bus.busy         = busy_q;
    assign bus.overflow     = overflow_q;
    assign bus.dropped_busy = dropped_q;
endmodule

// File: tb/tb_ps2_message_controller.sv
// tb/tb_ps2_message_controller.sv - directed self-checking bench for ps2_message_controller
module tb_ps2_message_controller;
    localparam int MSG_CHARS = 16;
    localparam int CNT_W     = 5;

    logic clock;
    logic RESETN;
    int   total;
    int   bad;

    ps2_message_controller_if #(.MSG_CHARS(MSG_CHARS), .CNT_W(CNT_W)) bus ();

    ps2_message_controller #(
        .MSG_CHARS    (MSG_CHARS),
        .CNT_W        (CNT_W),
        .CLEAR_ON_DONE(1)
    ) dut (
        .clock (clock),
        .RESETN(RESETN),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic key(input logic [7:0] c);
        bus.key_valid = 1'b1;
        bus.key_ascii = c;
        tick();
        bus.key_valid = 1'b0;
        bus.key_ascii = 8'h00;
    endtask

    task automatic pulse_reset();
        RESETN = 1'b0;
        #2;
        RESETN = 1'b1;
        tick();
    endtask

    logic [127:0] spaces;
    logic [127:0] all_a;

    initial begin
        total = 0;
        bad   = 0;
        spaces = {16{8'h20}};
        all_a  = {16{8'h61}};
        bus.key_valid = 1'b0;
        bus.key_ascii = 8'h00;
        bus.send_req  = 1'b0;
        bus.tx_done   = 1'b0;
        RESETN = 1'b1;
        #2;
        RESETN = 1'b0;
        tick();
        tick();
        check("rst_msg", bus.message, spaces);
        check("rst_cnt", 128'(bus.char_count), 128'd0);
        check("rst_flags", 128'({bus.data_ready, bus.busy, bus.overflow, bus.dropped_busy}), 128'd0);
        RESETN = 1'b1;
        tick();

        key(8'd104);
        key(8'd105);
        check("hi_cnt", 128'(bus.char_count), 128'd2);
        check("hi_msg", bus.message, {16'h6869, {14{8'h20}}});

        pulse_reset();
        key(8'h61);
        key(8'h62);
        check("ab_cnt", 128'(bus.char_count), 128'd2);
        key(8'd127);
        check("del1_cnt", 128'(bus.char_count), 128'd1);
        check("del1_msg", bus.message, {8'h61, {15{8'h20}}});
        key(8'd127);
        check("del2_cnt", 128'(bus.char_count), 128'd0);
        key(8'd127);
        check("del3_cnt", 128'(bus.char_count), 128'd0);
        check("del_msg", bus.message, spaces);
        check("del_ovf", 128'(bus.overflow), 128'd0);

        for (int i = 0; i < 16; i++) key(8'h61);
        check("full_cnt", 128'(bus.char_count), 128'd16);
        check("full_ovf0", 128'(bus.overflow), 128'd0);
`ifdef PS2_MSG_AUTO_SEND_EN
        tick();
        check("auto_dr", 128'(bus.data_ready), 128'd1);
        check("auto_msg", bus.message, all_a);
        pulse_reset();
`else
        check("full_dr", 128'(bus.data_ready), 128'd0);
        key(8'h61);
        check("ovf_cnt", 128'(bus.char_count), 128'd16);
        check("ovf_flag", 128'(bus.overflow), 128'd1);
        check("ovf_msg", bus.message, all_a);
        pulse_reset();
`endif

        bus.tx_done = 1'b1;
        tick();
        check("edit_txdone_busy", 128'(bus.busy), 128'd0);
        bus.tx_done = 1'b0;

        key(8'd104);
        key(8'd105);
        bus.send_req = 1'b1;
        tick();
        check("send_lat1_dr", 128'(bus.data_ready), 128'd0);
        tick();
        check("send_dr", 128'(bus.data_ready), 128'd1);
        check("send_busy", 128'(bus.busy), 128'd1);
        key(8'h7a);
        check("drop_flag", 128'(bus.dropped_busy), 128'd1);
        check("drop_cnt", 128'(bus.char_count), 128'd2);
        check("drop_msg", bus.message, {16'h6869, {14{8'h20}}});
        bus.send_req = 1'b0;
        tick();
        bus.send_req = 1'b1;
        tick();
        bus.tx_done = 1'b1;
        tick();
        check("done_dr", 128'(bus.data_ready), 128'd0);
        check("done_busy", 128'(bus.busy), 128'd1);
        bus.tx_done = 1'b0;
        tick();
        tick();
        tick();
        check("clr_cnt", 128'(bus.char_count), 128'd0);
        check("clr_busy", 128'(bus.busy), 128'd0);
        check("clr_msg", bus.message, spaces);
        check("clr_drop_sticky", 128'(bus.dropped_busy), 128'd1);
        check("no_queued_send", 128'(bus.data_ready), 128'd0);

        bus.send_req = 1'b0;
        tick();
        bus.key_valid = 1'b1;
        bus.key_ascii = 8'd113;
        bus.send_req  = 1'b1;
        tick();
        bus.key_valid = 1'b0;
        tick();
        check("coin_dr", 128'(bus.data_ready), 128'd1);
        check("coin_slot0", 128'(bus.message[127:120]), 128'h71);
        check("coin_cnt", 128'(bus.char_count), 128'd1);

        RESETN = 1'b0;
        #1;
        check("async_rst", 128'({bus.data_ready, bus.busy, bus.dropped_busy}), 128'd0);
        check("async_cnt", 128'(bus.char_count), 128'd0);
        #1;
        RESETN = 1'b1;
        tick();
        tick();
        tick();
        check("primed_no_send", 128'(bus.data_ready), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
